// File: rtl/mult_seq_ctrl_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mult_seq_ctrl_pkg;

   // Default operand width; legal range is 2..16.
   localparam int DEF_WIDTH = 8;

   // Controller states. Encoding 2'd3 is unused and falls back to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mult_iter_cnt.sv
// Step counter for the multiplier: clear, count-enable, terminal count at WIDTH-1.
// Latency: tc is combinational from the registered count.
// Backpressure: none; counts whenever enabled.
module mult_iter_cnt #(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0] cnt;

   // Clear wins over enable so a new operation always starts counting from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add multiplier controller driving an external WIDTH-bit adder.
// Latency: done pulses WIDTH+1 cycles after an accepted start; one result per WIDTH+2 cycles.
// Backpressure: start is only honoured in IDLE; requests while busy or done are dropped.
module mult_seq_ctrl
   import mult_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic [WIDTH-1:0]   add_a,
   output logic [WIDTH-1:0]   add_b,
   input  logic [WIDTH-1:0]   add_sum,
   input  logic               add_cout
);

   state_t             state;
   logic [WIDTH-1:0]   mc;
   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH-1:0]   acc_lo;
   logic [2*WIDTH-1:0] step_nxt;
   logic               cnt_clr;
   logic               cnt_en;
   logic               tc;

   // Adder carry becomes the new MSB; the consumed multiplier bit falls off the bottom.
   assign step_nxt = {add_cout, add_sum, acc_lo[WIDTH-1:1]};

   // Adder operands are driven from registers only, and held at zero outside RUN.
   assign add_a = (state == ST_RUN) ? acc_hi : '0;
   assign add_b = ((state == ST_RUN) && acc_lo[0]) ? mc : '0;

   assign cnt_clr = (state == ST_IDLE) && start;
   assign cnt_en  = (state == ST_RUN);

   mult_iter_cnt #(
      .WIDTH (WIDTH)
   ) u_iter_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .tc  (tc)
   );

   // Control FSM plus datapath registers; busy/done are registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         mc      <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         product <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mc     <= mcand;
                  acc_hi <= '0;
                  acc_lo <= mplier;
                  busy   <= 1'b1;
                  state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               {acc_hi, acc_lo} <= step_nxt;
               if (tc) begin
                  // Last step: publish the finished accumulator straight into product.
                  product <= step_nxt;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl with a behavioural adder and cycle-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mult_seq_ctrl;

   localparam int W = 8;

   logic           clk;
   logic           rst;
   logic           start;
   logic [W-1:0]   mcand;
   logic [W-1:0]   mplier;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;
   logic [W-1:0]   add_a;
   logic [W-1:0]   add_b;
   logic [W-1:0]   add_sum;
   logic           add_cout;

   int vectors     = 0;
   int miscompares = 0;

   mult_seq_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mcand    (mcand),
      .mplier   (mplier),
      .busy     (busy),
      .done     (done),
      .product  (product),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

   // Behavioural external adder.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: age = cycles since acceptance (-1 when idle). Busy for ages 0..W-1,
   // done at age W, product = operands multiplied together.
   int m_age;
   int m_mc;
   int m_mp;
   int m_prod;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_age  <= -1;
         m_mc   <= 0;
         m_mp   <= 0;
         m_prod <= 0;
      end else if (m_age < 0) begin
         if (start) begin
            m_age <= 0;
            m_mc  <= int'(mcand);
            m_mp  <= int'(mplier);
         end
      end else if (m_age < W) begin
         m_age <= m_age + 1;
         if (m_age == W - 1) m_prod <= m_mc * m_mp;
      end else begin
         m_age <= -1;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      int exp_busy, exp_done, exp_a, exp_b, k;
      if (!rst) begin
         exp_busy = (m_age >= 0 && m_age < W) ? 1 : 0;
         exp_done = (m_age == W) ? 1 : 0;
         exp_a = 0;
         exp_b = 0;
         if (exp_busy == 1) begin
            // After k steps the high half holds mc*(low k multiplier bits) >> k.
            k = m_age;
            exp_a = (m_mc * (m_mp % (1 << k))) >> k;
            exp_b = ((m_mp >> k) & 1) ? m_mc : 0;
         end
         check("busy", int'(busy), exp_busy);
         check("done", int'(done), exp_done);
         check("add_a", int'(add_a), exp_a);
         check("add_b", int'(add_b), exp_b);
         check("product", int'(product), m_prod);
      end
   end

   // One operation with hand-computed product; returns the carrying-step count.
   task automatic run_op(input int a, input int b, input int lit, output int couts);
      int n;
      @(negedge clk);
      start = 1'b1; mcand = W'(a); mplier = W'(b);
      @(negedge clk);
      start = 1'b0;
      n = 1;
      couts = (busy && add_cout) ? 1 : 0;
      while (!done && n < 30) begin
         @(negedge clk);
         n++;
         if (busy && add_cout) couts++;
      end
      check("latency", n, W + 1);
      check("product_lit", int'(product), lit);
   endtask

   initial begin
      int couts, n, ndone;
      int done_at[8];

      rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_product", int'(product), 0);
      check("rst_add_a", int'(add_a), 0);
      check("rst_add_b", int'(add_b), 0);
      #1 rst = 1'b0;

      run_op(13, 11, 143, couts);
      run_op(255, 255, 65025, couts);
      check("max_carry_steps", couts, 7);
      run_op(0, 200, 0, couts);
      run_op(200, 0, 0, couts);

      // Start while busy is dropped; operand changes after acceptance are ignored.
      @(negedge clk);
      start = 1'b1; mcand = 8'd6; mplier = 8'd5;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; mcand = 8'd7; mplier = 8'd9;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("busy_start_done_seen", int'(done), 1);
      check("busy_start_product", int'(product), 30);
      run_op(7, 9, 63, couts);

      // Asynchronous reset in the middle of RUN.
      @(negedge clk);
      start = 1'b1; mcand = 8'd100; mplier = 8'd100;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_product", int'(product), 0);
      check("midrst_add_a", int'(add_a), 0);
      check("midrst_add_b", int'(add_b), 0);
      @(negedge clk);
      #1 rst = 1'b0;
      run_op(3, 3, 9, couts);

      // start held high with operands changing every cycle.
      ndone = 0;
      for (int j = 0; j < 44; j++) begin
         @(negedge clk);
         if (done && ndone < 8) begin
            done_at[ndone] = j;
            ndone++;
         end
         start  = 1'b1;
         mcand  = W'((j * 37 + 5) & 255);
         mplier = W'((j * 91 + 17) & 255);
      end
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      check("b2b_done_count", ndone, 4);
      for (int i = 1; i < ndone; i++) check("b2b_interval", done_at[i] - done_at[i-1], W + 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
